// File: rtl/fp_pkg.sv
// Shared binary32 field definitions for the FPU test blocks.
// Provides the field widths, exponent bias and a packed result record.
package fp_pkg;

    localparam int FP32_EXP_BIAS = 127;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_FRAC_W   = 23;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_FRAC_W-1:0] frac;
    } fp32_t;

    function automatic fp32_t fp32_pack(input logic                   sign,
                                        input logic [FP32_EXP_W-1:0]  exp,
                                        input logic [FP32_FRAC_W-1:0] frac);
        fp32_t r;
        r.sign = sign;
        r.exp  = exp;
        r.frac = frac;
        return r;
    endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter with zero detect.
// An all-zero input reports a count of W.
module lzc #(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     data_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_s;

    // Scan from LSB upward so the highest set bit writes last and wins.
    always_comb begin
        cnt_s = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            cnt_s = data_i[i] ? CNT_W'(W - 1 - i) : cnt_s;
        end
    end

    assign cnt_o  = cnt_s;
    assign zero_o = ~|data_i;

endmodule

// File: rtl/int_to_fp_pipe.sv
// Three-stage integer to binary32 converter: capture, normalise, round/pack.
// A single advance enable stalls every stage together under output backpressure.
module int_to_fp_pipe
    import fp_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    input  logic             in_rtz,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_inexact,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LZ_W = $clog2(IN_W + 1);
    localparam logic [FP32_EXP_W-1:0] EXP_TOP = FP32_EXP_W'(FP32_EXP_BIAS + IN_W - 1);

    logic en_s;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q,  s1_sign_d;
    logic [IN_W-1:0]  s1_mag_q,   s1_mag_d;
    logic             s1_rtz_q,   s1_rtz_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sign_q,  s2_sign_d;
    logic                  s2_zero_q,  s2_zero_d;
    logic                  s2_rtz_q,   s2_rtz_d;
    logic [TAG_W-1:0]      s2_tag_q,   s2_tag_d;
    logic [FP32_EXP_W-1:0] s2_exp_q,   s2_exp_d;
    logic [IN_W-2:0]       s2_norm_q,  s2_norm_d;

    logic             out_valid_q,   out_valid_d;
    fp32_t            out_res_q,     out_res_d;
    logic             out_inexact_q, out_inexact_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;

    logic [LZ_W-1:0]        lz_s;
    logic                   lz_zero_s;
    logic [IN_W+23:0]       ext_s;
    logic [FP32_FRAC_W-1:0] frac_s;
    logic [FP32_FRAC_W:0]   frac_inc_s;
    logic                   guard_s;
    logic                   sticky_s;
    logic                   round_up_s;

    assign en_s     = !out_valid_q || out_ready;
    assign in_ready = en_s;

    // S1: sign detect and magnitude; the signed minimum negates to itself, which is the right magnitude.
    always_comb begin
        s1_valid_d = in_valid;
        s1_sign_d  = in_signed & in_data[IN_W-1];
        s1_mag_d   = s1_sign_d ? (~in_data + IN_W'(1)) : in_data;
        s1_rtz_d   = in_rtz;
        s1_tag_d   = in_tag;
    end

    lzc #(.W(IN_W)) u_lzc (
        .data_i (s1_mag_q),
        .cnt_o  (lz_s),
        .zero_o (lz_zero_s)
    );

    // S2: shift the leading one out of the top bit; only the bits below it are kept.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_sign_d  = s1_sign_q;
        s2_zero_d  = lz_zero_s;
        s2_rtz_d   = s1_rtz_q;
        s2_tag_d   = s1_tag_q;
        s2_exp_d   = EXP_TOP - FP32_EXP_W'(lz_s);
        s2_norm_d  = s1_mag_q[IN_W-2:0] << lz_s;
    end

    // S3: zero-extend below the fraction so narrow inputs round with guard = sticky = 0.
    assign ext_s      = {s2_norm_q, 25'd0};
    assign frac_s     = ext_s[IN_W+23 -: FP32_FRAC_W];
    assign guard_s    = ext_s[IN_W];
    assign sticky_s   = |ext_s[IN_W-1:0];
    assign round_up_s = !s2_rtz_q && guard_s && (sticky_s || frac_s[0]);
    assign frac_inc_s = {1'b0, frac_s} + 24'd1;

    // S3: pack; a fraction carry-out bumps the exponent and leaves the fraction at zero.
    always_comb begin
        out_valid_d   = s2_valid_q;
        out_tag_d     = s2_tag_q;
        out_res_d     = '0;
        out_inexact_d = 1'b0;
        if (s2_zero_q) begin
            out_res_d     = '0;
            out_inexact_d = 1'b0;
        end else if (round_up_s) begin
            out_res_d     = fp32_pack(s2_sign_q,
                                      frac_inc_s[FP32_FRAC_W] ? s2_exp_q + 8'd1 : s2_exp_q,
                                      frac_inc_s[FP32_FRAC_W-1:0]);
            out_inexact_d = 1'b1;
        end else begin
            out_res_d     = fp32_pack(s2_sign_q, s2_exp_q, frac_s);
            out_inexact_d = guard_s | sticky_s;
        end
    end

    // Stage registers, all advancing together on the shared enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_mag_q      <= '0;
            s1_rtz_q      <= 1'b0;
            s1_tag_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_zero_q     <= 1'b0;
            s2_rtz_q      <= 1'b0;
            s2_tag_q      <= '0;
            s2_exp_q      <= '0;
            s2_norm_q     <= '0;
            out_valid_q   <= 1'b0;
            out_res_q     <= '0;
            out_inexact_q <= 1'b0;
            out_tag_q     <= '0;
        end else if (en_s) begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_mag_q      <= s1_mag_d;
            s1_rtz_q      <= s1_rtz_d;
            s1_tag_q      <= s1_tag_d;
            s2_valid_q    <= s2_valid_d;
            s2_sign_q     <= s2_sign_d;
            s2_zero_q     <= s2_zero_d;
            s2_rtz_q      <= s2_rtz_d;
            s2_tag_q      <= s2_tag_d;
            s2_exp_q      <= s2_exp_d;
            s2_norm_q     <= s2_norm_d;
            out_valid_q   <= out_valid_d;
            out_res_q     <= out_res_d;
            out_inexact_q <= out_inexact_d;
            out_tag_q     <= out_tag_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_res_q;
    assign out_inexact = out_inexact_q;
    assign out_tag     = out_tag_q;

endmodule

// File: doc/int_to_fp_pipe.md
# int_to_fp_pipe

Pipelined, parametrised integer-to-IEEE-754 binary32 converter for the FPU test datapath. It generalises the combinational decimal-to-float conversion with several additions: configurable input width, runtime signed/unsigned selection, correct zero encoding, round-to-nearest-even or truncation, an inexact flag, and a valid/ready streaming handshake. It sits between the integer stimulus source and the FPU operand inputs, and sustains one conversion per cycle.

## Interface
- IN_W, 32: integer input width; legal range 8..64.
- TAG_W, 4: width of the sideband tag carried unchanged alongside each conversion.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  converter accepts the beat this cycle.
- in_data  in  IN_W  integer operand.
- in_signed  in  1  1 = two's complement, 0 = unsigned.
- in_rtz  in  1  1 = round toward zero, 0 = round to nearest, ties to even.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  binary32 result {sign, exp[7:0], frac[22:0]}.
- out_inexact  out  1  1 when the result differs from the exact integer value.
- out_tag  out  TAG_W  tag of this result.

## Operation
- Stage S1 (capture): sign = in_signed & in_data[IN_W-1]. mag = sign ? −in_data : in_data, taken as an IN_W-bit unsigned value. The signed minimum −2^(IN_W−1) gives mag = 2^(IN_W−1), which is correct. zero = (in_data == 0).
- Stage S2 (normalise): lz = leading-zero count of mag. p = IN_W−1−lz. norm = mag << lz, so the MSB lands at bit IN_W−1.
- Stage S3 (round/pack):
  - frac = norm[IN_W-2 -: 23]; missing low bits are zero-filled when IN_W−1 < 23.
  - guard = the next bit below frac; sticky = OR of all remaining lower bits.
  - RNE: increment when guard & (sticky | frac[0]). RTZ: never increment.
  - If frac is all ones and increments, frac becomes 0 and exp becomes 127+p+1.
  - exp = 127+p. With IN_W ≤ 64 the maximum is 191, so overflow and infinity cannot occur.
  - inexact = guard | sticky.
- Zero input gives out_data = 32'h0000_0000 (+0 in both modes) and inexact = 0.
- The tag, in_signed and in_rtz travel with the data through every stage.

## Timing
- Latency: 3 cycles from input handshake to out_valid, with no stall.
- Throughput: 1 beat per cycle.
- Stall model: one global advance enable, en = !out_valid | out_ready.
  - in_ready = en. The ready path is combinational from out_ready.
  - When en = 0, all stage registers and their valid bits hold. A stalled output holds out_data, out_inexact and out_tag stable.
  - Bubbles are not compressed while stalled.
- An input beat is accepted only when in_valid & in_ready. A beat presented while in_ready = 0 is not captured and must be held by the source.
- Reset, asynchronous and applicable at any time including mid-stream:
  - all stage valids clear to 0 and in-flight beats are discarded;
  - out_valid = 0, out_data = 0, out_inexact = 0, out_tag = 0;
  - in_ready = 1 from the first cycle after reset deasserts.
- Simultaneous out_ready and in_valid on a full pipe: the output retires and a new beat enters in the same cycle, with no bubble.

## Structure
- Package fp_pkg: FP32_EXP_BIAS = 127, FP32_EXP_W = 8, FP32_FRAC_W = 23, and a packed struct fp32_t {sign, exp, frac}. The package is shared with the other FPU test blocks.
- Sub-module lzc, parametrised by width W: combinational leading-zero count with a zero-detect output. It is instantiated in S2 and is reusable elsewhere.
- Stage registers are implemented inline in int_to_fp_pipe; the target is roughly 200 lines total.

## Test plan
- Zero and unity, IN_W = 32, signed, RNE: 0 → 32'h0000_0000, inexact 0; 1 → 32'h3F80_0000; 32'hFFFF_FFFF signed → 32'hBF80_0000.
- Extremes: 32'h8000_0000 signed → 32'hCF00_0000, inexact 0. 32'hFFFF_FFFF unsigned: RNE → 32'h4F80_0000, inexact 1; RTZ → 32'h4F7F_FFFF, inexact 1.
- Ties, unsigned, RNE: 16777217 → 32'h4B80_0000 and 16777219 → 32'h4B80_0002, both inexact 1. 16777216 → 32'h4B80_0000, inexact 0.
- Backpressure: stream 20 random beats with unique tags while out_ready toggles pseudo-randomly. Results must match a reference model, in order, with no drops or duplicates. Output fields must stay stable while out_valid & !out_ready.
- Reset mid-stream: assert rst_n = 0 with 3 beats in flight. out_valid must drop immediately and no stale beat may appear after release. The first new beat must emerge exactly 3 cycles after acceptance.
- Width sweep at IN_W = 8, 16 and 64: exhaustive test for 8 bits, random for the others. Signed minimum at IN_W = 64 → 32'hDF00_0000.
